// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator producing pixel strobe, x/y coordinates, syncs, blanking and frame start.
module vga_sync_gen #(
    parameter int   CLK_DIV   = 2,
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div;
    logic [9:0]    h, v, h_nxt, v_nxt;
    logic          h_wrap;

    always_comb begin
        p_tick      = (div == DIV_LAST) && !reset;
        h_wrap      = p_tick && h == H_LAST;
        h_nxt       = h_wrap ? '0 : h + 10'(p_tick);
        v_nxt       = h_wrap ? (v == V_LAST ? '0 : v + 10'd1) : v;
        frame_start = h_wrap && v == V_LAST;
    end

    // syncs and blanking decode next-state counters so they line up with x/y
    always_ff @(posedge clk) begin
        if (reset) begin
            div      <= '0;
            h        <= '0;
            v        <= '0;
            hsync    <= ~SYNC_POL;
            vsync    <= ~SYNC_POL;
            video_on <= 1'b0;
        end else begin
            div      <= p_tick ? '0 : div + DW'(1);
            h        <= h_nxt;
            v        <= v_nxt;
            hsync    <= (h_nxt >= HS_START && h_nxt <= HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync    <= (v_nxt >= VS_START && v_nxt <= VS_END) ? SYNC_POL : ~SYNC_POL;
            video_on <= h_nxt < H_VIS && v_nxt < V_VIS;
        end
    end

    assign x = h;
    assign y = v;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of default, CLK_DIV=1/active-high and reduced-timing builds.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic pt_a, hs_a, vs_a, vo_a, fs_a;
    logic pt_b, hs_b, vs_b, vo_b, fs_b;
    logic pt_c, hs_c, vs_c, vo_c, fs_c;
    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
    int checks = 0, errors = 0;
    int k_a, k_b, k_c;

    vga_sync_gen dut_a (
        .clk(clk), .reset(rst_a), .p_tick(pt_a), .x(x_a), .y(y_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .frame_start(fs_a)
    );

    vga_sync_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) dut_b (
        .clk(clk), .reset(rst_b), .p_tick(pt_b), .x(x_b), .y(y_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .frame_start(fs_b)
    );

    // reduced timing: 15 pixels x 10 lines, hsync at x 10..12, vsync at y 5..6
    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
    ) dut_c (
        .clk(clk), .reset(rst_c), .p_tick(pt_c), .x(x_c), .y(y_c),
        .hsync(hs_c), .vsync(vs_c), .video_on(vo_c), .frame_start(fs_c)
    );

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (x_a !== 10'd0 || y_a !== 10'd0) begin
            errors++; $display("FAIL reset_xy: got x=%0d y=%0d, want 0 0", x_a, y_a);
        end
        checks++;
        if ({hs_a, vs_a} !== 2'b11) begin
            errors++; $display("FAIL reset_sync: got hs=%b vs=%b, want 1 1", hs_a, vs_a);
        end
        checks++;
        if ({pt_a, fs_a, vo_a} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got pt=%b fs=%b vo=%b, want 0 0 0", pt_a, fs_a, vo_a);
        end
        checks++;
        if ({hs_b, vs_b, pt_b} !== 3'b000) begin
            errors++; $display("FAIL reset_pol1: got hs=%b vs=%b pt=%b, want 0 0 0", hs_b, vs_b, pt_b);
        end
        @(negedge clk);
        rst_a = 1'b0;
        k_a = 1;
        #1;
        checks++;
        if (pt_a !== 1'b0 || vo_a !== 1'b0) begin
            errors++; $display("FAIL release_cycle1: got pt=%b vo=%b, want 0 0", pt_a, vo_a);
        end
        @(negedge clk);
        k_a = 2;
        #1;
        checks++;
        if (pt_a !== 1'b1 || vo_a !== 1'b1 || x_a !== 10'd0) begin
            errors++; $display("FAIL release_cycle2: got pt=%b vo=%b x=%0d, want 1 1 0", pt_a, vo_a, x_a);
        end
    endtask

    task automatic test_line;
        int n, ex, ey, low;
        low = 0;
        while (k_a < 1602) begin
            @(negedge clk);
            k_a++;
            #1;
            n = (k_a - 1) / 2;
            ex = n % 800;
            ey = (n / 800) % 525;
            if (!hs_a) low++;
            checks++;
            if (x_a !== 10'(ex) || y_a !== 10'(ey)) begin
                errors++; $display("FAIL line_xy k=%0d: got %0d,%0d want %0d,%0d", k_a, x_a, y_a, ex, ey);
            end
            checks++;
            if (pt_a !== (k_a % 2 == 0)) begin
                errors++; $display("FAIL line_ptick k=%0d: got %b", k_a, pt_a);
            end
            checks++;
            if (hs_a !== !(ex >= 656 && ex <= 751)) begin
                errors++; $display("FAIL line_hsync x=%0d: got %b", ex, hs_a);
            end
            checks++;
            if (vo_a !== (ex < 640 && ey < 480)) begin
                errors++; $display("FAIL line_video_on x=%0d: got %b", ex, vo_a);
            end
            checks++;
            if (vs_a !== 1'b1 || fs_a !== 1'b0) begin
                errors++; $display("FAIL line_vs_fs x=%0d: got vs=%b fs=%b want 1 0", ex, vs_a, fs_a);
            end
        end
        checks++;
        if (low !== 192) begin
            errors++; $display("FAIL hsync_width: got %0d clk, want 192", low);
        end
        checks++;
        if (x_a !== 10'd0 || y_a !== 10'd1) begin
            errors++; $display("FAIL line_wrap: got %0d,%0d want 0,1", x_a, y_a);
        end
    endtask

    task automatic test_mid_reset_default;
        int n;
        repeat (3002 - k_a) @(negedge clk);
        k_a = 3002;
        #1;
        checks++;
        if (x_a !== 10'd700 || y_a !== 10'd1 || hs_a !== 1'b0 || pt_a !== 1'b1) begin
            errors++; $display("FAIL pre_reset: got x=%0d y=%0d hs=%b pt=%b want 700 1 0 1", x_a, y_a, hs_a, pt_a);
        end
        rst_a = 1'b1;
        #1;
        checks++;
        if (pt_a !== 1'b0 || fs_a !== 1'b0) begin
            errors++; $display("FAIL reset_gates_ptick: got pt=%b fs=%b want 0 0", pt_a, fs_a);
        end
        @(negedge clk);
        #1;
        checks++;
        if (x_a !== 10'd0 || y_a !== 10'd0 || {hs_a, vs_a, vo_a} !== 3'b110) begin
            errors++; $display("FAIL mid_reset_a: got x=%0d y=%0d hs=%b vs=%b vo=%b", x_a, y_a, hs_a, vs_a, vo_a);
        end
        rst_a = 1'b0;
        k_a = 1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) begin
                @(negedge clk);
                k_a++;
            end
            #1;
            n = (k_a - 1) / 2;
            checks++;
            if (x_a !== 10'(n) || y_a !== 10'd0 || pt_a !== (k_a % 2 == 0) || vo_a !== (k_a >= 2)) begin
                errors++; $display("FAIL restart_a k=%0d: got x=%0d y=%0d pt=%b vo=%b", k_a, x_a, y_a, pt_a, vo_a);
            end
        end
    endtask

    task automatic test_frame_small;
        int n, ex, ey, vlow, fs_cnt, fs_first, fs_second;
        vlow = 0; fs_cnt = 0; fs_first = 0; fs_second = 0;
        @(negedge clk);
        rst_c = 1'b0;
        k_c = 0;
        repeat (700) begin
            if (k_c > 0) @(negedge clk);
            k_c++;
            #1;
            n = (k_c - 1) / 2;
            ex = n % 15;
            ey = (n / 15) % 10;
            if (k_c <= 300 && !vs_c) vlow++;
            if (fs_c) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_first = k_c;
                if (fs_cnt == 2) fs_second = k_c;
            end
            checks++;
            if (x_c !== 10'(ex) || y_c !== 10'(ey) || pt_c !== (k_c % 2 == 0)) begin
                errors++; $display("FAIL frame_xy k=%0d: got %0d,%0d pt=%b want %0d,%0d", k_c, x_c, y_c, pt_c, ex, ey);
            end
            checks++;
            if (hs_c !== !(ex >= 10 && ex <= 12) || vs_c !== !(ey >= 5 && ey <= 6)) begin
                errors++; $display("FAIL frame_sync (%0d,%0d): got hs=%b vs=%b", ex, ey, hs_c, vs_c);
            end
            checks++;
            if (vo_c !== (k_c >= 2 && ex < 8 && ey < 4)) begin
                errors++; $display("FAIL frame_video_on (%0d,%0d): got %b", ex, ey, vo_c);
            end
            checks++;
            if (fs_c !== (k_c % 2 == 0 && ex == 14 && ey == 9)) begin
                errors++; $display("FAIL frame_start (%0d,%0d) k=%0d: got %b", ex, ey, k_c, fs_c);
            end
        end
        checks++;
        if (vlow !== 60) begin
            errors++; $display("FAIL vsync_width: got %0d clk, want 60", vlow);
        end
        checks++;
        if (fs_cnt !== 2 || fs_first !== 300 || fs_second - fs_first !== 300) begin
            errors++; $display("FAIL frame_period: got cnt=%0d first=%0d second=%0d want 2 300 600", fs_cnt, fs_first, fs_second);
        end
    endtask

    task automatic test_mid_reset_small;
        int fs_k;
        fs_k = 0;
        repeat (806 - k_c) @(negedge clk);
        k_c = 806;
        #1;
        checks++;
        if (x_c !== 10'd12 || y_c !== 10'd6 || {hs_c, vs_c, pt_c} !== 3'b001) begin
            errors++; $display("FAIL pre_reset_c: got x=%0d y=%0d hs=%b vs=%b pt=%b", x_c, y_c, hs_c, vs_c, pt_c);
        end
        rst_c = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (x_c !== 10'd0 || y_c !== 10'd0 || {hs_c, vs_c, vo_c, fs_c, pt_c} !== 5'b11000) begin
            errors++; $display("FAIL mid_reset_c: got x=%0d y=%0d hs=%b vs=%b vo=%b fs=%b pt=%b", x_c, y_c, hs_c, vs_c, vo_c, fs_c, pt_c);
        end
        rst_c = 1'b0;
        k_c = 0;
        repeat (320) begin
            if (k_c > 0) @(negedge clk);
            k_c++;
            #1;
            if (fs_c && fs_k == 0) fs_k = k_c;
        end
        checks++;
        if (fs_k !== 300) begin
            errors++; $display("FAIL restart_c_frame: first frame_start at k=%0d, want 300", fs_k);
        end
    endtask

    task automatic test_div1_pol1;
        int n, ex, high, wrap_k;
        high = 0; wrap_k = 0;
        @(negedge clk);
        rst_b = 1'b0;
        k_b = 0;
        repeat (802) begin
            if (k_b > 0) @(negedge clk);
            k_b++;
            #1;
            n = k_b - 1;
            ex = n % 800;
            if (hs_b) high++;
            if (k_b > 1 && x_b == 10'd0 && wrap_k == 0) wrap_k = k_b;
            checks++;
            if (pt_b !== 1'b1 || x_b !== 10'(ex) || y_b !== 10'(n / 800)) begin
                errors++; $display("FAIL div1_xy k=%0d: got pt=%b x=%0d y=%0d", k_b, pt_b, x_b, y_b);
            end
            checks++;
            if (hs_b !== (ex >= 656 && ex <= 751) || vs_b !== 1'b0 || vo_b !== (k_b >= 2 && ex < 640)) begin
                errors++; $display("FAIL div1_out x=%0d: got hs=%b vs=%b vo=%b", ex, hs_b, vs_b, vo_b);
            end
        end
        checks++;
        if (high !== 96) begin
            errors++; $display("FAIL div1_hsync_width: got %0d, want 96", high);
        end
        checks++;
        if (wrap_k !== 801) begin
            errors++; $display("FAIL div1_line_period: wrap at k=%0d, want 801", wrap_k);
        end
    endtask

    initial begin
        test_reset;
        test_line;
        test_mid_reset_default;
        test_frame_small;
        test_mid_reset_small;
        test_div1_pol1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator for the VGA pixel path: produces hsync/vsync, the blanking qualifier and the current pixel coordinates x/y.
- Sits directly upstream of the shape/overlay display stages; its x/y outputs drive their coordinate inputs, and video_on gates their colour outputs.
- Default timing: 640x480 @ 60 Hz from a 50 MHz system clock (25 MHz pixel rate).

Parameters:
- CLK_DIV, 2, clk cycles per pixel (>=1)
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- p_tick  output  1  pixel-enable strobe, one clk wide
- x  output  10  current horizontal count (0..H_TOTAL-1)
- y  output  10  current vertical count (0..V_TOTAL-1)
- hsync  output  1  horizontal sync, polarity per SYNC_POL
- vsync  output  1  vertical sync, polarity per SYNC_POL
- video_on  output  1  high when x<H_DISPLAY and y<V_DISPLAY
- frame_start  output  1  one-clk pulse on the pixel step into (0,0)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, sampled on rising clk only.
- Derived totals:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
  - Both must be <=1024; x/y are 10-bit unsigned.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div==CLK_DIV-1) && !reset.
  - With CLK_DIV=1, p_tick is high every non-reset cycle.
- Horizontal counter h: advances only on clk edges where p_tick=1. At H_TOTAL-1 it wraps to 0.
- Vertical counter v: advances only on an h wrap. At V_TOTAL-1 it wraps to 0 on the same edge that h wraps.
- Coordinates: x = h, y = v, taken directly from the registers.
- hsync, vsync and video_on are registered. Each clk they are computed from the next-state h/v, so they are cycle-aligned with x/y.
  - hsync active when H_DISPLAY+H_FRONT <= h <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync active when V_DISPLAY+V_FRONT <= v <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
  - vsync depends on v only; it changes on the line-wrap edge.
- frame_start = p_tick && h==H_TOTAL-1 && v==V_TOTAL-1. It is high in the clk cycle before x/y become (0,0).
- Reset values while reset=1:
  - div=0, x=0, y=0, p_tick=0, frame_start=0.
  - hsync=vsync=~SYNC_POL (inactive), video_on=0.
- After reset release:
  - video_on becomes 1 on the first clk edge (decoded from (0,0)).
  - First p_tick occurs CLK_DIV cycles after the release edge.
- Reset mid-frame: on the next edge all state returns to reset values regardless of h/v/div. There is no partial-line completion.
- Outputs never glitch. The sync window checks use >= and <=, with no off-by-one outside the pulse widths.
- Per frame: exactly H_TOTAL*V_TOTAL p_ticks (420000), i.e. 840000 clk cycles at defaults.

Test Plan:
- Reset, then release → x=y=0, hsync=vsync=1, video_on=1 after the first edge. p_tick pulses every 2nd clk (first at cycle 2), never two consecutive cycles.
- Run one line at y=0 → x steps 0..799 then back to 0 with y=1. hsync low exactly for x=656..751 (96 pixels = 192 clk), high at x=655 and x=752.
- Run a full frame → vsync low only for y=490 and y=491 (1600 p_ticks). video_on=1 at (639,479), 0 at (640,479) and (0,480).
- Frame wrap → at (799,524) with p_tick, frame_start=1 for exactly one clk, next x=y=0. Exactly 840000 clk between successive frame_start pulses.
- Assert reset for 1 clk at (700,491), inside both sync windows → next cycle x=y=0, hsync=vsync=1, video_on=0, frame_start=0. Timing restarts identically to a cold reset.
- CLK_DIV=1, SYNC_POL=1 build → p_tick constant 1 out of reset, hsync high for x=656..751, line period 800 clk.
